// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared types and constants for the FP multiply scheduler
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;

endpackage

// File: rtl/floating_multiplier.sv
// rtl/floating_multiplier.sv - combinational single-precision multiplier
module floating_multiplier
    import fp_mul_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    localparam int PW = 2 * MANT_W + 2;

    logic [PW-1:0]     sig_a;
    logic [PW-1:0]     sig_b;
    logic [PW-1:0]     prod;
    logic              norm;
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp_r;

    // No special-case handling: zero/denormal/Inf/NaN go through the same path.
    always_comb begin
        sig_a = {{(MANT_W + 1){1'b0}}, 1'b1, a[MANT_W-1:0]};
        sig_b = {{(MANT_W + 1){1'b0}}, 1'b1, b[MANT_W-1:0]};
        prod  = sig_a * sig_b;
        norm  = prod[PW-1];
        if (norm) begin
            mant = prod[PW-2:MANT_W+1] + {{(MANT_W - 1){1'b0}}, prod[MANT_W]};
        end else begin
            mant = prod[PW-3:MANT_W] + {{(MANT_W - 1){1'b0}}, prod[MANT_W-1]};
        end
        exp_r = a[MANT_W+EXP_W-1:MANT_W] + b[MANT_W+EXP_W-1:MANT_W]
              - EXP_W'(EXP_BIAS) + {{(EXP_W - 1){1'b0}}, norm};
        p     = {a[31] ^ b[31], exp_r, mant};
    end

endmodule

// File: rtl/fp_mul_scheduler.sv
// rtl/fp_mul_scheduler.sv - round-robin sharing of one FP multiplier by two requesters
module fp_mul_scheduler
    import fp_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_id,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        id_q, id_d;
    logic [31:0] res_data_q, res_data_d;
    logic        res_id_q, res_id_d;
    logic        res_valid_q, res_valid_d;

    logic        any_valid;
    logic        grant;
    logic [31:0] mul_p;

    floating_multiplier u_mul (
        .a (a_q),
        .b (b_q),
        .p (mul_p)
    );

    // Pointer only breaks ties; a lone requester is always granted.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ptr_q;
        end else begin
            grant = ~req0_valid;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_valid && !rst) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    a_d        = grant ? req1_a : req0_a;
                    b_d        = grant ? req1_b : req0_b;
                    id_d       = grant;
                    ptr_d      = ~grant;
                    state_d    = CALC;
                end
            end
            CALC: begin
                res_data_d  = mul_p;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/fp_mul_scheduler.md
FP_MUL_SCHEDULER -- requirements
Module: fp_mul_scheduler

Interface
REQ-001 Port clk  input  1  Single clock; all state updates on its rising edge.
REQ-002 Port rst  input  1  Reset; synchronous, active-high.
REQ-003 Port req0_valid  input  1  Requester 0 has an operand pair.
REQ-004 Port req0_a, req0_b  input  32 each  Requester 0 IEEE-754 single operands.
REQ-005 Port req0_ready  output  1  Requester 0 pair accepted this cycle when high with req0_valid.
REQ-006 Port req1_valid, req1_a, req1_b, req1_ready  as REQ-003..005  Requester 1.
REQ-007 Port res_valid  output  1  Result held on res_data/res_id.
REQ-008 Port res_ready  input  1  Consumer accepts result.
REQ-009 Port res_data  output  32  Product of the granted pair.
REQ-010 Port res_id  output  1  Index of the requester that owns res_data.
REQ-011 Port busy  output  1  High in any state other than IDLE.

Function
REQ-012 The block SHALL share one combinational FP multiplier between two requesters, one operation in flight at a time.
REQ-013 The FSM SHALL have states IDLE, CALC and HOLD.
REQ-014 In IDLE, the block SHALL assert reqN_ready only for the granted requester.
- Grant goes to the single valid requester, or by round-robin pointer when both are valid.
- Both ready outputs SHALL be low in CALC and HOLD.
REQ-015 On handshake (valid and ready both high) in IDLE, the block SHALL:
- register a, b and the requester index;
- move to CALC;
- set the pointer to the non-granted requester.
REQ-016 In CALC, the block SHALL register the multiplier output into res_data and res_id, assert res_valid, and move to HOLD.
REQ-017 In HOLD, res_valid, res_data and res_id SHALL stay stable until res_ready is high; on that edge the block SHALL drop res_valid and return to IDLE.
REQ-018 Latency: a handshake at edge N SHALL give res_valid high after edge N+2.
- Minimum issue interval is 3 cycles with res_ready tied high.
REQ-019 The pointer SHALL change only on a grant.
- With one requester valid, it SHALL be granted every time regardless of the pointer.
REQ-020 Requests raised during CALC or HOLD SHALL wait, and SHALL be arbitrated on return to IDLE.
REQ-021 A requester dropping valid before its handshake SHALL lose nothing and SHALL not block the other requester.
REQ-022 The product SHALL follow the existing multiplier arithmetic exactly:
- sign = XOR of the operand signs;
- exponent = ea + eb - 127, plus 1 when product bit 47 is set (8-bit wraparound, no saturation);
- mantissa = 24x24 product of the hidden-1 significands, normalized, rounded by adding the first dropped bit;
- no special-case handling of zero, denormal, Inf or NaN.

Reset
REQ-023 While rst is high at a clock edge, the block SHALL clear all state: FSM to IDLE, pointer to requester 0, both readys 0, res_valid 0, res_data 0, res_id 0, busy 0.
REQ-024 Reset in CALC or HOLD SHALL discard the in-flight operation; no res_valid SHALL appear for it after reset.

Structure
REQ-025 A shared package fp_mul_pkg SHALL hold:
- the state enum (IDLE/CALC/HOLD);
- constants EXP_BIAS=127, EXP_W=8, MANT_W=23.
REQ-026 The block SHALL instantiate exactly one floating_multiplier sub-module, fed from the operand registers.
- Arbitration, FSM and output registers SHALL be local to fp_mul_scheduler.

Verification
REQ-027 Requester 0 only, 0x40000000 x 0x40400000, res_ready=1 -> res_valid after 2 cycles; res_data=0x40C00000, res_id=0.
REQ-028 Both requesters valid after reset, req0 1.5x1.5 (0x3FC00000 both), req1 0xC0000000 x 0x40400000 -> first result 0x40100000 id 0, then 0xC0C00000 id 1.
REQ-029 res_ready held low 5 cycles in HOLD -> res_data/res_id stable, both readys low, busy=1 throughout; release -> IDLE next cycle.
REQ-030 Both requesters valid continuously for 6 operations -> grants strictly alternate 0,1,0,1,0,1.
REQ-031 rst asserted in CALC -> next cycle res_valid=0, FSM IDLE, pointer=0; no stale result afterward.
REQ-032 req1_valid pulsed for one cycle while busy, then dropped -> req1 never granted and req1_ready stays low.
